lsu_controller: RTL and testbench

- Sequences every load/store from the execute stage onto a single data-memory request/response port.
- Decodes funct3 into access width and signedness, and generates the word-aligned address, byte enables and replicated store data.
- Stalls the pipeline while an access is outstanding, then returns aligned, sign- or zero-extended load data.
- Flags misaligned and illegal accesses and bus timeouts without touching memory.

---
 rtl/lsu_pkg.sv | 62 ++++++
 rtl/lsu_load_align.sv | 34 +++
 rtl/lsu_controller.sv | 138 +++++++++++++
 tb/tb_lsu_controller.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types, funct3 encodings and store-formatting helpers for the load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } width_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int TIMEOUT_DEFAULT = 255;

  function automatic width_t f3_width(input logic [1:0] f3_lo);
    case (f3_lo)
      2'b00:   return BYTE;
      2'b01:   return HALF;
      default: return WORD;
    endcase
  endfunction

  function automatic logic f3_legal(input logic [2:0] f3, input logic is_store);
    if (is_store) return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  function automatic logic is_misaligned(input width_t w, input logic [1:0] lo);
    case (w)
      HALF:    return lo[0];
      WORD:    return lo != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] store_byte_en(input width_t w, input logic [1:0] lo);
    case (w)
      BYTE:    return 4'b0001 << lo;
      HALF:    return 4'b0011 << {lo[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_wdata(input width_t w, input logic [31:0] d);
    case (w)
      BYTE:    return {4{d[7:0]}};
      HALF:    return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Picks the addressed byte/half out of a read word and sign- or zero-extends it.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] iRData,
  input  logic [1:0]  iAddrLo,
  input  logic [2:0]  iFunct3,
  output logic [31:0] oData
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    case (iAddrLo)
      2'd0:    w_byte = iRData[7:0];
      2'd1:    w_byte = iRData[15:8];
      2'd2:    w_byte = iRData[23:16];
      default: w_byte = iRData[31:24];
    endcase
    w_half = iAddrLo[1] ? iRData[31:16] : iRData[15:0];
  end

  always_comb begin
    case (iFunct3)
      F3_B:    oData = {{24{w_byte[7]}}, w_byte};
      F3_BU:   oData = {24'd0, w_byte};
      F3_H:    oData = {{16{w_half[15]}}, w_half};
      F3_HU:   oData = {16'd0, w_half};
      default: oData = iRData;
    endcase
  end

endmodule

// File: rtl/lsu_controller.sv
// Load/store sequencer: one access at a time onto a single memory req/resp port.
// Handshake: a request transfers in any REQ cycle where oMemReq && iMemReady; read data is
// taken only in WAIT when iMemRValid is high; the request fields are registers and never move while pending.
module lsu_controller
  import lsu_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iLoad,
  input  logic              iStore,
  input  logic [2:0]        iFunct3,
  input  logic [ADDR_W-1:0] iAddr,
  input  logic [DATA_W-1:0] iStoreData,
  output logic              oStall,
  output logic              oDone,
  output logic              oLoadValid,
  output logic [DATA_W-1:0] oLoadData,
  output logic              oMisaligned,
  output logic              oIllegal,
  output logic              oBusErr,
  output logic              oMemReq,
  output logic              oMemWe,
  output logic [ADDR_W-1:0] oMemAddr,
  output logic [3:0]        oMemByteEn,
  output logic [DATA_W-1:0] oMemWData,
  input  logic              iMemReady,
  input  logic              iMemRValid,
  input  logic [DATA_W-1:0] iMemRData,
  output logic [1:0]        oDbgState
);

  state_t              r_state;
  state_t              w_next_state;
  logic [ADDR_W-1:0]   r_addr;
  logic [2:0]          r_funct3;
  logic                r_is_store;
  logic [DATA_W-1:0]   r_wdata;
  logic [3:0]          r_byte_en;
  logic [7:0]          r_tcnt;
  logic                r_err;
  logic [DATA_W-1:0]   r_load_data;

  width_t              w_width;
  logic                w_req;
  logic                w_illegal;
  logic                w_misal;
  logic                w_accept;
  logic                w_timeout_hit;
  logic [DATA_W-1:0]   w_aligned;

  always_comb begin
    w_width   = f3_width(iFunct3[1:0]);
    w_req     = (iLoad || iStore) && !iRst && (r_state == S_IDLE);
    w_illegal = !f3_legal(iFunct3, iStore);
    w_misal   = is_misaligned(w_width, iAddr[1:0]);
    w_accept  = w_req && !w_illegal && !w_misal;
  end

  // The TIMEOUT-th cycle spent in REQ+WAIT without progress aborts the access.
  always_comb begin
    w_timeout_hit = (r_tcnt == 8'(TIMEOUT - 1)) &&
                    (((r_state == S_REQ) && !iMemReady) ||
                     ((r_state == S_WAIT) && !iMemRValid));
  end

  lsu_load_align u_align (
    .iRData  (iMemRData),
    .iAddrLo (r_addr[1:0]),
    .iFunct3 (r_funct3),
    .oData   (w_aligned)
  );

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) r_state <= S_IDLE;
    else      r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next_state = S_REQ;
      S_REQ: begin
        if (iMemReady)          w_next_state = r_is_store ? S_DONE : S_WAIT;
        else if (w_timeout_hit) w_next_state = S_DONE;
      end
      S_WAIT: if (iMemRValid || w_timeout_hit) w_next_state = S_DONE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_addr      <= '0;
      r_funct3    <= '0;
      r_is_store  <= 1'b0;
      r_wdata     <= '0;
      r_byte_en   <= '0;
      r_tcnt      <= '0;
      r_err       <= 1'b0;
      r_load_data <= '0;
    end else begin
      if (w_accept) begin
        r_addr     <= iAddr;
        r_funct3   <= iFunct3;
        r_is_store <= iStore;
        r_wdata    <= iStore ? store_wdata(w_width, iStoreData) : '0;
        r_byte_en  <= iStore ? store_byte_en(w_width, iAddr[1:0]) : 4'b1111;
        r_tcnt     <= '0;
        r_err      <= 1'b0;
      end else if ((r_state == S_REQ) || (r_state == S_WAIT)) begin
        if (w_timeout_hit) r_err  <= 1'b1;
        else               r_tcnt <= r_tcnt + 8'd1;
      end
      if ((r_state == S_WAIT) && iMemRValid) r_load_data <= w_aligned;
    end
  end

  always_comb begin
    oStall      = (r_state == S_REQ) || (r_state == S_WAIT) || w_accept;
    oDone       = (r_state == S_DONE);
    oLoadValid  = (r_state == S_DONE) && !r_is_store && !r_err;
    oBusErr     = (r_state == S_DONE) && r_err;
    oIllegal    = w_req && w_illegal;
    oMisaligned = w_req && !w_illegal && w_misal;
    oMemReq     = (r_state == S_REQ);
    oMemWe      = (r_state == S_REQ) && r_is_store;
    oMemAddr    = {r_addr[ADDR_W-1:2], 2'b00};
    oMemByteEn  = r_byte_en;
    oMemWData   = r_wdata;
    oLoadData   = r_load_data;
    oDbgState   = r_state;
  end

endmodule

// File: tb/tb_lsu_controller.sv
// Directed bench for lsu_controller with a scoreboard of expected stores and load results.
module tb_lsu_controller;

  logic        iClk, iRst, iLoad, iStore;
  logic [2:0]  iFunct3;
  logic [31:0] iAddr, iStoreData;
  logic        oStall, oDone, oLoadValid, oMisaligned, oIllegal, oBusErr;
  logic [31:0] oLoadData;
  logic        oMemReq, oMemWe;
  logic [31:0] oMemAddr, oMemWData;
  logic [3:0]  oMemByteEn;
  logic        iMemReady, iMemRValid;
  logic [31:0] iMemRData;
  logic [1:0]  oDbgState;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [67:0] st_q[$];

  lsu_controller dut (
    .iClk(iClk), .iRst(iRst), .iLoad(iLoad), .iStore(iStore), .iFunct3(iFunct3),
    .iAddr(iAddr), .iStoreData(iStoreData), .oStall(oStall), .oDone(oDone),
    .oLoadValid(oLoadValid), .oLoadData(oLoadData), .oMisaligned(oMisaligned),
    .oIllegal(oIllegal), .oBusErr(oBusErr), .oMemReq(oMemReq), .oMemWe(oMemWe),
    .oMemAddr(oMemAddr), .oMemByteEn(oMemByteEn), .oMemWData(oMemWData),
    .iMemReady(iMemReady), .iMemRValid(iMemRValid), .iMemRData(iMemRData),
    .oDbgState(oDbgState)
  );

  initial begin
    iClk = 1'b0;
    forever #5 iClk = ~iClk;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench timed out");
  end

  task automatic check(input string tag, input logic [67:0] got, input logic [67:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] lo,
                                             input logic [31:0] rd);
    logic [31:0] s;
    s = rd >> (8 * lo);
    case (f3)
      3'b000:  return {{24{s[7]}}, s[7:0]};
      3'b100:  return {24'd0, s[7:0]};
      3'b001:  return {{16{s[15]}}, s[15:0]};
      3'b101:  return {16'd0, s[15:0]};
      default: return rd;
    endcase
  endfunction

  function automatic logic [67:0] model_store(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] d);
    logic [3:0]  be;
    logic [31:0] wd;
    case (f3)
      3'b000:  begin be = 4'b0001 << a[1:0]; wd = {4{d[7:0]}}; end
      3'b001:  begin be = a[1] ? 4'b1100 : 4'b0011; wd = {2{d[15:0]}}; end
      default: begin be = 4'b1111; wd = d; end
    endcase
    return {a & 32'hFFFF_FFFC, be, wd};
  endfunction

  task automatic next_cycle();
    @(posedge iClk);
    #1;
  endtask

  // Drives one access from IDLE and plays memory; called at posedge+1.
  task automatic run_access(input logic ld, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] sdata, input int rdy_dly,
                            input logic [31:0] rdata, input int rv_dly,
                            input int exp_cycles, input logic exp_err);
    int cyc, req_k, wait_k;
    logic accepted, finished;
    logic [31:0] last_ld;
    logic [67:0] st_e;
    iLoad = ld; iStore = !ld; iFunct3 = f3; iAddr = addr; iStoreData = sdata;
    iMemReady = 1'b0; iMemRValid = 1'b0; iMemRData = '0;
    last_ld = model_load(f3, addr[1:0], rdata);
    if (!exp_err) begin
      if (ld) exp_q.push_back(last_ld);
      else    st_q.push_back(model_store(f3, addr, sdata));
    end
    #1;
    check("stall_on_accept", oStall, 1'b1);
    cyc = 1; req_k = 0; wait_k = 0; accepted = 1'b0; finished = 1'b0;
    while (!finished) begin
      next_cycle();
      cyc++;
      iMemReady = 1'b0; iMemRValid = 1'b0;
      if (oDone) begin
        finished = 1'b1;
        check("done_cycle", cyc, exp_cycles);
        check("done_stall", oStall, 1'b0);
        check("done_buserr", oBusErr, exp_err);
        check("done_loadvalid", oLoadValid, ld && !exp_err);
        if (oLoadValid) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL load_data: got %0h expected nothing", oLoadData);
          end else begin
            last_ld = exp_q.pop_front();
            checks--;
            check("load_data", oLoadData, last_ld);
          end
        end
      end else if (cyc > exp_cycles + 20) begin
        finished = 1'b1;
        check("access_bound", cyc, exp_cycles);
      end else begin
        check("stall_busy", oStall, 1'b1);
        if (oMemReq) begin
          check("req_addr", oMemAddr, addr & 32'hFFFF_FFFC);
          check("req_we", oMemWe, !ld);
          if (req_k == rdy_dly) begin
            iMemReady = 1'b1;
            accepted = 1'b1;
            if (!ld) begin
              checks++;
              if (st_q.size() == 0) begin
                errors++;
                $error("FAIL store_req: got %0h expected nothing", {oMemAddr, oMemByteEn, oMemWData});
              end else begin
                st_e = st_q.pop_front();
                checks--;
                check("store_req", {oMemAddr, oMemByteEn, oMemWData}, st_e);
              end
            end else begin
              check("load_byte_en", oMemByteEn, 4'b1111);
              iMemRValid = 1'b1;
              iMemRData = 32'hBAD0_BAD0;
            end
          end
          req_k++;
        end else if (accepted && ld) begin
          if (wait_k == rv_dly) begin
            iMemRValid = 1'b1;
            iMemRData = rdata;
          end
          wait_k++;
        end else begin
          check("req_present", oMemReq, 1'b1);
        end
      end
    end
    next_cycle();
    check("idle_after_done", {oDone, oMemReq, oBusErr, oLoadValid}, 4'b0000);
    if (ld && !exp_err) check("load_data_hold", oLoadData, last_ld);
    iLoad = 1'b0; iStore = 1'b0; iMemRValid = 1'b0;
    #1;
  endtask

  task automatic run_reject(input logic ld, input logic [2:0] f3, input logic [31:0] addr,
                            input logic exp_mis, input logic exp_ill);
    iLoad = ld; iStore = !ld; iFunct3 = f3; iAddr = addr; iStoreData = 32'h1111_2222;
    #1;
    check("rej_misaligned", oMisaligned, exp_mis);
    check("rej_illegal", oIllegal, exp_ill);
    check("rej_stall", oStall, 1'b0);
    next_cycle();
    check("rej_stays_idle", {oMemReq, oStall, oDone}, 3'b000);
    iLoad = 1'b0; iStore = 1'b0;
    #1;
    check("rej_pulse_clear", {oMisaligned, oIllegal}, 2'b00);
  endtask

  initial begin
    iRst = 1'b1; iLoad = 1'b0; iStore = 1'b0; iFunct3 = '0; iAddr = '0; iStoreData = '0;
    iMemReady = 1'b0; iMemRValid = 1'b0; iMemRData = '0;
    #1;
    check("reset_flags", {oStall, oDone, oLoadValid, oMisaligned, oIllegal, oBusErr, oMemReq, oMemWe}, 8'h00);
    check("reset_bus", {oMemAddr, oMemByteEn, oMemWData}, 68'd0);
    check("reset_loaddata", oLoadData, 32'd0);
    check("reset_state", oDbgState, 2'd0);
    next_cycle();
    next_cycle();
    iRst = 1'b0;
    next_cycle();

    run_access(1'b0, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 0, '0, 0, 3, 1'b0);
    run_access(1'b0, 3'b000, 32'h0000_0103, 32'h0000_00A5, 0, '0, 0, 3, 1'b0);
    run_access(1'b0, 3'b001, 32'h0000_0102, 32'h1234_BEEF, 1, '0, 0, 4, 1'b0);
    run_access(1'b0, 3'b000, 32'h0000_0201, 32'h0000_0077, 0, '0, 0, 3, 1'b0);

    run_access(1'b1, 3'b000, 32'h0000_0102, '0, 2, 32'h12F0_3456, 0, 6, 1'b0);
    run_access(1'b1, 3'b100, 32'h0000_0102, '0, 0, 32'h12F0_3456, 0, 4, 1'b0);
    run_access(1'b1, 3'b101, 32'h0000_0102, '0, 0, 32'h12F0_3456, 1, 5, 1'b0);
    run_access(1'b1, 3'b001, 32'h0000_0100, '0, 0, 32'h0000_8001, 0, 4, 1'b0);
    run_access(1'b1, 3'b001, 32'h0000_0302, '0, 0, 32'h7FFF_0000, 0, 4, 1'b0);
    run_access(1'b1, 3'b010, 32'h0000_0104, '0, 1, 32'hCAFE_F00D, 2, 7, 1'b0);
    for (int i = 0; i < 4; i++) begin
      logic [31:0] rd;
      rd = $urandom_range(32'hFFFF_FFFF, 0);
      run_access(1'b1, (i % 2 == 0) ? 3'b000 : 3'b100, 32'h0000_0400 + 32'(i), '0, 0, rd, 0, 4, 1'b0);
    end

    run_reject(1'b1, 3'b010, 32'h0000_0101, 1'b1, 1'b0);
    run_reject(1'b1, 3'b001, 32'h0000_0103, 1'b1, 1'b0);
    run_reject(1'b0, 3'b010, 32'h0000_0102, 1'b1, 1'b0);
    run_reject(1'b1, 3'b011, 32'h0000_0100, 1'b0, 1'b1);
    run_reject(1'b1, 3'b011, 32'h0000_0101, 1'b0, 1'b1);
    run_reject(1'b0, 3'b100, 32'h0000_0100, 1'b0, 1'b1);

    run_access(1'b0, 3'b010, 32'h0000_0500, 32'h0BAD_0BAD, 100000, '0, 0, 257, 1'b1);
    run_access(1'b1, 3'b010, 32'h0000_0500, '0, 0, 32'h5555_AAAA, 0, 4, 1'b0);

    iLoad = 1'b1; iStore = 1'b0; iFunct3 = 3'b010; iAddr = 32'h0000_0200;
    next_cycle();
    check("rst_test_req", oMemReq, 1'b1);
    iMemReady = 1'b1;
    next_cycle();
    iMemReady = 1'b0; iLoad = 1'b0;
    check("rst_test_wait", {oMemReq, oStall}, 2'b01);
    #2;
    iRst = 1'b1;
    #1;
    check("rst_mid_flags", {oStall, oDone, oLoadValid, oBusErr, oMemReq, oMemWe}, 6'd0);
    check("rst_mid_bus", {oMemAddr, oMemByteEn, oMemWData}, 68'd0);
    check("rst_mid_loaddata", oLoadData, 32'd0);
    check("rst_mid_state", oDbgState, 2'd0);
    next_cycle();
    iRst = 1'b0;
    iMemRValid = 1'b1; iMemRData = 32'h1234_5678;
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      check("late_rvalid_ignored", {oLoadValid, oDone, oStall}, 3'b000);
    end
    iMemRValid = 1'b0;

    check("exp_q_drained", exp_q.size(), 0);
    check("st_q_drained", st_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
